// File: rtl/elevator_pkg.sv
// Shared types and default constants for the elevator SCAN/LOOK controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMove = 2'd1,
    StDoor = 2'd2
  } state_e;

  localparam int unsigned DefNumFloors    = 16;
  localparam int unsigned DefTravelCycles = 8;
  localparam int unsigned DefDoorCycles   = 4;

  // Floor index width; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter; o_done flags the last cycle of a loaded interval.
module elev_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == W'(1));

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller with LOOK scheduling, travel/door timers and
// a pending-request bitmap.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned  NUM_FLOORS    = DefNumFloors,
  parameter int unsigned  TRAVEL_CYCLES = DefTravelCycles,
  parameter int unsigned  DOOR_CYCLES   = DefDoorCycles,
  parameter int unsigned  REQ_W         = clog2_min1(NUM_FLOORS),
  localparam int unsigned FLOOR_W       = clog2_min1(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [REQ_W-1:0]      req_floor,
  output logic                  req_err,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned TimerMax = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0]  TravelLoad = TimerW'(TRAVEL_CYCLES);
  localparam logic [TimerW-1:0]  DoorLoad   = TimerW'(DOOR_CYCLES);
  localparam logic [FLOOR_W-1:0] TopFloor   = FLOOR_W'(NUM_FLOORS - 1);

  state_e                  r_state, w_state_nxt;
  logic [FLOOR_W-1:0]      r_cur_floor, w_floor_nxt;
  logic                    r_dir_up, w_dir_nxt;
  logic [NUM_FLOORS-1:0]   r_pending;
  logic                    r_req_err;

  logic                    w_trav_load, w_door_load, w_trav_done, w_door_done;
  int unsigned             w_req_idx, w_cur_idx;
  logic                    w_req_ok, w_req_here, w_arrive_req, w_stop;
  logic [FLOOR_W-1:0]      w_req_fl, w_step_floor;
  logic [NUM_FLOORS-1:0]   w_set_mask, w_clr_mask, w_mask_above, w_mask_below;
  logic                    w_pend_above, w_pend_below, w_ahead, w_behind, w_near_up;
  int unsigned             w_dist_up, w_dist_dn;
  logic                    w_found_up;

  // Decode the request against the full input width so wide encodings are caught.
  assign w_req_idx    = 32'(req_floor);
  assign w_cur_idx    = 32'(r_cur_floor);
  assign w_req_ok     = req_valid && (w_req_idx < NUM_FLOORS);
  assign w_req_fl     = req_floor[FLOOR_W-1:0];
  assign w_req_here   = w_req_ok && (w_req_fl == r_cur_floor);
  assign w_arrive_req = w_req_ok && (w_req_fl == w_step_floor);
  assign w_stop       = r_pending[w_step_floor] || w_arrive_req;

  always_comb begin
    w_step_floor = r_cur_floor;
    if (r_dir_up && (r_cur_floor != TopFloor)) begin
      w_step_floor = r_cur_floor + FLOOR_W'(1);
    end else if (!r_dir_up && (r_cur_floor != '0)) begin
      w_step_floor = r_cur_floor - FLOOR_W'(1);
    end
  end

  always_comb begin
    w_mask_above = '0;
    w_mask_below = '0;
    w_dist_up    = NUM_FLOORS;
    w_dist_dn    = NUM_FLOORS;
    w_found_up   = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      w_mask_above[i] = (i > w_cur_idx);
      w_mask_below[i] = (i < w_cur_idx);
      if (r_pending[i] && (i < w_cur_idx)) begin
        w_dist_dn = w_cur_idx - i;
      end
      if (r_pending[i] && (i > w_cur_idx) && !w_found_up) begin
        w_dist_up  = i - w_cur_idx;
        w_found_up = 1'b1;
      end
    end
  end

  assign w_pend_above = |(r_pending & w_mask_above);
  assign w_pend_below = |(r_pending & w_mask_below);
  assign w_ahead      = r_dir_up ? w_pend_above : w_pend_below;
  assign w_behind     = r_dir_up ? w_pend_below : w_pend_above;
  // Ties go down.
  assign w_near_up    = (w_dist_up < w_dist_dn);

  always_comb begin
    w_set_mask = '0;
    if (w_req_ok && (!w_req_here || (r_state == StMove))) begin
      w_set_mask[w_req_fl] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_cur_floor;
    w_dir_nxt   = r_dir_up;
    w_trav_load = 1'b0;
    w_door_load = 1'b0;
    w_clr_mask  = '0;
    unique case (r_state)
      StIdle: begin
        if (w_req_here) begin
          w_state_nxt = StDoor;
          w_door_load = 1'b1;
        end else if (w_pend_above || w_pend_below) begin
          w_state_nxt = StMove;
          w_trav_load = 1'b1;
          w_dir_nxt   = w_near_up;
        end
      end
      StMove: begin
        if (w_trav_done) begin
          w_floor_nxt = w_step_floor;
          if (w_step_floor == TopFloor) begin
            w_dir_nxt = 1'b0;
          end else if (w_step_floor == '0) begin
            w_dir_nxt = 1'b1;
          end
          if (w_stop) begin
            w_state_nxt              = StDoor;
            w_door_load              = 1'b1;
            w_clr_mask[w_step_floor] = 1'b1;
          end else begin
            w_trav_load = 1'b1;
          end
        end
      end
      StDoor: begin
        if (w_req_here) begin
          w_door_load = 1'b1;
        end else if (w_door_done) begin
          if (w_ahead) begin
            w_state_nxt = StMove;
            w_trav_load = 1'b1;
          end else if (w_behind) begin
            w_state_nxt = StMove;
            w_trav_load = 1'b1;
            w_dir_nxt   = ~r_dir_up;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cur_floor <= '0;
      r_dir_up    <= 1'b1;
      r_pending   <= '0;
      r_req_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_floor <= w_floor_nxt;
      r_dir_up    <= w_dir_nxt;
      r_pending   <= (r_pending | w_set_mask) & ~w_clr_mask;
      r_req_err   <= req_valid && !w_req_ok;
    end
  end

  elev_timer #(
    .W (TimerW)
  ) u_travel_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_trav_load),
    .i_load_val (TravelLoad),
    .o_done     (w_trav_done)
  );

  elev_timer #(
    .W (TimerW)
  ) u_door_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_door_load),
    .i_load_val (DoorLoad),
    .o_done     (w_door_done)
  );

  assign req_err   = r_req_err;
  assign cur_floor = r_cur_floor;
  assign dir_up    = r_dir_up;
  assign moving    = (r_state == StMove);
  assign door_open = (r_state == StDoor);
  assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed, table-driven bench for elevator_scan_ctrl (8 floors, 4/3-cycle timers).
module tb_elevator_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_floor = '0;
  logic       req_err;
  logic [2:0] cur_floor;
  logic       dir_up, moving, door_open;
  logic [7:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       v;
    logic [3:0] f;
    int         n;
    logic       err;
    logic [2:0] cur;
    logic       dir;
    logic       mov;
    logic       door;
    logic [7:0] pend;
  } vec_t;

  vec_t vecs[$];

  elevator_scan_ctrl #(
    .NUM_FLOORS    (8),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3),
    .REQ_W         (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_err   (req_err),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic v, input logic [3:0] f, input int n, input logic err,
                              input logic [2:0] cur, input logic dir, input logic mov,
                              input logic door, input logic [7:0] pend);
    vec_t e;
    e.v = v; e.f = f; e.n = n; e.err = err; e.cur = cur;
    e.dir = dir; e.mov = mov; e.door = door; e.pend = pend;
    vecs.push_back(e);
  endfunction

  task automatic check(input string tag, input int row, input int cyc, input logic err,
                       input logic [2:0] cur, input logic dir, input logic mov,
                       input logic door, input logic [7:0] pend);
    n_checks++;
    if ({req_err, cur_floor, dir_up, moving, door_open, pending} !==
        {err, cur, dir, mov, door, pend}) begin
      n_fail++;
      $display("FAIL %s row %0d cyc %0d: got err=%0b floor=%0d up=%0b mov=%0b door=%0b pend=%02h, want err=%0b floor=%0d up=%0b mov=%0b door=%0b pend=%02h",
               tag, row, cyc, req_err, cur_floor, dir_up, moving, door_open, pending,
               err, cur, dir, mov, door, pend);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vectors(input string tag);
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        req_valid = (k == 0) ? vecs[i].v : 1'b0;
        req_floor = vecs[i].f;
        step();
        check(tag, i, k, vecs[i].err, vecs[i].cur, vecs[i].dir, vecs[i].mov,
              vecs[i].door, vecs[i].pend);
      end
    end
    req_valid = 1'b0;
    vecs.delete();
  endtask

  initial begin
    bit reached;

    #1 reset = 1'b0;
    #1 check("reset_async", -1, 0, 0, 3'd0, 1, 0, 0, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Single trip to 3, then 4, then LOOK service of 6 and 1, door restart, errors.
    //   v  f   n  err cur dir mov door pend
    add(1, 3,  1, 0, 3'd0, 1, 0, 0, 8'h08);
    add(0, 0,  4, 0, 3'd0, 1, 1, 0, 8'h08);
    add(0, 0,  4, 0, 3'd1, 1, 1, 0, 8'h08);
    add(0, 0,  4, 0, 3'd2, 1, 1, 0, 8'h08);
    add(0, 0,  3, 0, 3'd3, 1, 0, 1, 8'h00);
    add(0, 0,  1, 0, 3'd3, 1, 0, 0, 8'h00);
    add(1, 4,  1, 0, 3'd3, 1, 0, 0, 8'h10);
    add(0, 0,  4, 0, 3'd3, 1, 1, 0, 8'h10);
    add(0, 0,  3, 0, 3'd4, 1, 0, 1, 8'h00);
    add(0, 0,  1, 0, 3'd4, 1, 0, 0, 8'h00);
    add(1, 6,  1, 0, 3'd4, 1, 0, 0, 8'h40);
    add(1, 1,  1, 0, 3'd4, 1, 1, 0, 8'h42);
    add(0, 0,  3, 0, 3'd4, 1, 1, 0, 8'h42);
    add(0, 0,  4, 0, 3'd5, 1, 1, 0, 8'h42);
    add(0, 0,  3, 0, 3'd6, 1, 0, 1, 8'h02);
    add(0, 0,  4, 0, 3'd6, 0, 1, 0, 8'h02);
    add(0, 0,  4, 0, 3'd5, 0, 1, 0, 8'h02);
    add(0, 0,  4, 0, 3'd4, 0, 1, 0, 8'h02);
    add(0, 0,  4, 0, 3'd3, 0, 1, 0, 8'h02);
    add(0, 0,  4, 0, 3'd2, 0, 1, 0, 8'h02);
    add(0, 0,  3, 0, 3'd1, 0, 0, 1, 8'h00);
    add(0, 0,  1, 0, 3'd1, 0, 0, 0, 8'h00);
    add(1, 2,  1, 0, 3'd1, 0, 0, 0, 8'h04);
    add(0, 0,  4, 0, 3'd1, 1, 1, 0, 8'h04);
    add(0, 0,  2, 0, 3'd2, 1, 0, 1, 8'h00);
    add(1, 2,  3, 0, 3'd2, 1, 0, 1, 8'h00);
    add(0, 0,  1, 0, 3'd2, 1, 0, 0, 8'h00);
    add(1, 9,  1, 1, 3'd2, 1, 0, 0, 8'h00);
    add(1, 8,  1, 1, 3'd2, 1, 0, 0, 8'h00);
    add(1, 15, 1, 1, 3'd2, 1, 0, 0, 8'h00);
    add(0, 0,  1, 0, 3'd2, 1, 0, 0, 8'h00);
    add(1, 2,  3, 0, 3'd2, 1, 0, 1, 8'h00);
    add(0, 0,  1, 0, 3'd2, 1, 0, 0, 8'h00);
    run_vectors("tblA");

    @(negedge clk);
    reset = 1'b0;
    #1 check("reset_mid", -1, 0, 0, 3'd0, 1, 0, 0, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Trip 0->5 with a request for 2 placed behind the car at floor 3.
    add(1, 5,  1, 0, 3'd0, 1, 0, 0, 8'h20);
    add(0, 0,  4, 0, 3'd0, 1, 1, 0, 8'h20);
    add(0, 0,  4, 0, 3'd1, 1, 1, 0, 8'h20);
    add(0, 0,  4, 0, 3'd2, 1, 1, 0, 8'h20);
    add(0, 0,  1, 0, 3'd3, 1, 1, 0, 8'h20);
    add(1, 2,  1, 0, 3'd3, 1, 1, 0, 8'h24);
    add(0, 0,  2, 0, 3'd3, 1, 1, 0, 8'h24);
    add(0, 0,  4, 0, 3'd4, 1, 1, 0, 8'h24);
    add(0, 0,  3, 0, 3'd5, 1, 0, 1, 8'h04);
    add(0, 0,  4, 0, 3'd5, 0, 1, 0, 8'h04);
    add(0, 0,  4, 0, 3'd4, 0, 1, 0, 8'h04);
    add(0, 0,  4, 0, 3'd3, 0, 1, 0, 8'h04);
    add(0, 0,  3, 0, 3'd2, 0, 0, 1, 8'h00);
    add(0, 0,  1, 0, 3'd2, 0, 0, 0, 8'h00);
    run_vectors("tblB");

    // Top-floor request, then an asynchronous reset while passing floor 5.
    req_valid = 1'b1;
    req_floor = 4'd7;
    step();
    req_valid = 1'b0;
    check("req_top", -1, 0, 0, 3'd2, 0, 0, 0, 8'h80);
    reached = 1'b0;
    for (int c = 0; c < 60 && !reached; c++) begin
      step();
      if (cur_floor == 3'd5 && moving) reached = 1'b1;
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL reach_floor5: got floor=%0d mov=%0b, want floor=5 mov=1 within 60 cycles",
               cur_floor, moving);
    end
    #2 reset = 1'b0;
    #1 check("reset_in_move", -1, 0, 0, 3'd0, 1, 0, 0, 8'h00);
    step();
    check("reset_held", -1, 0, 0, 3'd0, 1, 0, 0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("post_reset_idle", -1, c, 0, 3'd0, 1, 0, 0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 16: number of served floors, numbered 0..NUM_FLOORS-1, minimum 2.
REQ-002 Parameter TRAVEL_CYCLES, default 8: clock cycles to travel between adjacent floors, minimum 1.
REQ-003 Parameter DOOR_CYCLES, default 4: clock cycles the door stays open per stop, minimum 1.
REQ-004 Derived constant FLOOR_W = $clog2(NUM_FLOORS), minimum 1.
REQ-005 Port clk  input  1: the single clock; all state changes on its rising edge.
REQ-006 Port reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-007 Port req_valid  input  1: a floor-button press is presented this cycle.
REQ-008 Port req_floor  input  FLOOR_W: floor requested, sampled when req_valid=1.
REQ-009 Port req_err  output  1: one-cycle pulse, request was out of range.
REQ-010 Port cur_floor  output  FLOOR_W: floor the car is currently at or last passed.
REQ-011 Port dir_up  output  1: 1 = current/last direction up, 0 = down.
REQ-012 Port moving  output  1: car is travelling between floors.
REQ-013 Port door_open  output  1: door is open at cur_floor.
REQ-014 Port pending  output  NUM_FLOORS: bitmap of outstanding requests, bit i = floor i.

Function
REQ-015 States SHALL be IDLE, MOVE, DOOR; moving=1 only in MOVE, door_open=1 only in DOOR.
REQ-016 Valid in-range request for a floor != cur_floor, or for cur_floor while in MOVE, SHALL set pending[req_floor]; visible on the next cycle.
REQ-017 Request with req_floor >= NUM_FLOORS SHALL be dropped and pulse req_err for exactly one cycle the following cycle.
REQ-018 Request for cur_floor in IDLE SHALL enter DOOR next cycle without setting pending; in DOOR it SHALL restart the door timer to DOOR_CYCLES.
REQ-019 IDLE with pending != 0: next cycle SHALL enter MOVE; direction = toward nearest pending floor; equal distance -> down.
REQ-020 MOVE: travel timer loaded with TRAVEL_CYCLES on entry; on expiry cur_floor SHALL step by +1 (dir_up=1) or -1 (dir_up=0).
REQ-021 On arrival, if pending[cur_floor new] is set, it SHALL clear that bit and enter DOOR; otherwise reload timer and continue in MOVE.
REQ-022 A request for the arrival floor in the arrival cycle SHALL be absorbed (clear wins, no second stop).
REQ-023 DOOR lasts DOOR_CYCLES cycles (subject to REQ-018); on expiry: pending ahead in dir_up -> MOVE same direction; else pending behind -> reverse dir_up, MOVE; else IDLE.
REQ-024 Requests behind the car while in MOVE SHALL be held until no requests remain ahead (LOOK scheduling).
REQ-025 cur_floor SHALL never leave 0..NUM_FLOORS-1; direction is forced down at top and up at floor 0.
REQ-026 dir_up SHALL retain its value in IDLE.

Reset
REQ-027 reset=0 SHALL asynchronously force: state IDLE, cur_floor 0, dir_up 1, pending 0, moving 0, door_open 0, req_err 0, timers 0.
REQ-028 Reset asserted mid-MOVE or mid-DOOR SHALL discard all pending requests; operation resumes from IDLE at floor 0 on the first edge after release.

Structure
REQ-029 Shared package elevator_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-030 One sub-module, elev_timer (loadable down-counter with done flag), SHALL be instantiated for both travel and door timing.
REQ-031 Ahead/behind detection SHALL be a combinational masked-OR of pending against cur_floor.

Verification (NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-032 Reset, request 3 -> MOVE up, cur_floor 1,2,3 at 4-cycle spacing, door_open 3 cycles, IDLE, pending 0.
REQ-033 Idle at 4, requests 6 and 1 same time window -> serves 6 first (distance 2 < 3), then reverses to 1.
REQ-034 Moving 0->5, request 2 arrives while at floor 3 -> stops at 5, then reverses and stops at 2.
REQ-035 Request 9 (req_floor width widened in test) or invalid encoding -> req_err pulse 1 cycle, pending unchanged.
REQ-036 In DOOR at floor 2, request 2 on door cycle 2 -> door_open extends 3 more cycles, pending[2] stays 0.
REQ-037 reset=0 mid-MOVE at floor 5 -> outputs reach reset values without a clock edge; after release car idles at 0.
